// File: rtl/program_memory_loader_pkg.sv
// program_memory_loader_pkg: state encodings and constants shared by the program memory loader.
package program_memory_loader_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/program_memory_loader_byte_word_assembler.sv
// program_memory_loader_byte_word_assembler: packs accepted bytes little-endian into a 32-bit word.
module program_memory_loader_byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Right shift lands the first byte in bits [7:0] once four bytes are in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 2'd0;
            r_word <= 32'h0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= 32'h0;
        end else if (i_accept) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[31:8]};
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = i_accept && (r_cnt == 2'd3);

endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: arbitrates the program memory port between CPU fetch and a byte-stream loader.
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [DATA_WIDTH-1:0] pc_address,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  r_byte_ready;
    logic                  r_stall;
    logic                  r_wr_en;
    logic                  r_done;
    logic                  r_error;

    logic                  w_len_ok;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_word_valid;
    logic                  w_last;
    logic [31:0]           w_word;

    assign w_len_ok = (load_len != '0) && (load_len <= MAX_LEN);
    assign w_start  = (r_state == ST_RUN) && load_req && w_len_ok;
    assign w_accept = byte_valid && r_byte_ready;
    assign w_last   = ({1'b0, r_index} + (ADDR_WIDTH+1)'(1)) == r_len;

    program_memory_loader_byte_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start),
        .i_accept     (w_accept),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_index      <= '0;
            r_len        <= '0;
            r_byte_ready <= 1'b0;
            r_stall      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_start) begin
                        r_len        <= load_len;
                        r_index      <= '0;
                        r_state      <= ST_LOAD;
                        r_stall      <= 1'b1;
                        r_byte_ready <= 1'b1;
                    end else if (load_req) begin
                        r_error <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_word_valid) begin
                        r_state      <= ST_WRITE;
                        r_byte_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_index <= r_index + ADDR_WIDTH'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_LOAD;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // Outside RUN the memory port is owned by the loader so fetch cannot disturb it.
    assign mem_address    = (r_state == ST_RUN) ? pc_address
                          : {{(DATA_WIDTH-ADDR_WIDTH-2){1'b0}}, r_index, 2'b00};
    assign instruction    = (r_state == ST_RUN) ? mem_read_data : NOP;
    assign mem_write_data = w_word;
    assign mem_write_en   = r_wr_en;
    assign byte_ready     = r_byte_ready;
    assign cpu_stall      = r_stall;
    assign load_done      = r_done;
    assign load_error     = r_error;

endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: scoreboard bench with a behavioural program memory behind the loader.
module tb_program_memory_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_req = 1'b0;
    logic [5:0]  load_len = 6'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h0;
    logic        byte_ready;
    logic [31:0] pc_address = 32'h0;
    logic [31:0] instruction;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic [31:0] mem_read_data;
    logic        load_done;
    logic        load_error;

    logic [31:0] mem [32];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    logic [31:0] words [4];

    always #5 clk = ~clk;

    program_memory_loader dut (
        .clk            (clk),
        .reset          (reset),
        .load_req       (load_req),
        .load_len       (load_len),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .pc_address     (pc_address),
        .instruction    (instruction),
        .cpu_stall      (cpu_stall),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    assign mem_read_data = mem[mem_address[6:2]];

    always @(posedge clk)
        if (mem_write_en) mem[mem_address[6:2]] <= mem_write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe is matched against the oldest expected (address, data) pair.
    always @(negedge clk) begin
        if (reset && mem_write_en) begin
            logic [63:0] e;
            n_writes++;
            chk("ready_in_write", {31'h0, byte_ready}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_address, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", mem_address, e[63:32]);
                chk("write_data", mem_write_data, e[31:0]);
            end
        end
    end

    task automatic start_load(input logic [5:0] len);
        load_req = 1'b1;
        load_len = len;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = byte_ready;
        end
        if (!ok) chk("byte_ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gap);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({32'(w * 4), words[w]});
            for (int k = 0; k < 4; k++) begin
                send_byte(words[w][8*k +: 8]);
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = load_done;
        end
        chk("done_seen", {31'h0, seen}, 32'h1);
        chk("stall_in_done", {31'h0, cpu_stall}, 32'h1);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, load_done}, 32'h0);
        chk("stall_after_done", {31'h0, cpu_stall}, 32'h0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        words[0] = 32'h1234_5678;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'hCAFE_F00D;
        words[3] = 32'h0BAD_C0DE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_ready", {31'h0, byte_ready}, 32'h0);
        chk("rst_we", {31'h0, mem_write_en}, 32'h0);
        chk("rst_done_err", {30'h0, load_done, load_error}, 32'h0);
        reset = 1'b1;
        pc_address = 32'h8;
        @(negedge clk);
        chk("run_addr", mem_address, 32'h8);
        chk("run_instr", instruction, 32'hA000_0002);
        chk("run_stall", {31'h0, cpu_stall}, 32'h0);

        // Two-word load, back-to-back bytes.
        @(posedge clk);
        #1 start_load(6'd2);
        @(negedge clk);
        chk("load_stall", {31'h0, cpu_stall}, 32'h1);
        chk("load_nop", instruction, 32'h0);
        chk("load_ready", {31'h0, byte_ready}, 32'h1);
        @(posedge clk);
        #1 send_words(2, 0);
        wait_done();
        chk("writes_after_2", 32'(n_writes), 32'd2);
        chk("mem0", mem[0], 32'h1234_5678);
        chk("mem1", mem[1], 32'hDEAD_BEEF);
        pc_address = 32'h4;
        #1 chk("fetch_loaded", instruction, 32'hDEAD_BEEF);

        // Illegal lengths are rejected without disturbing the CPU.
        foreach (words[i]) begin end
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1 start_load(t == 0 ? 6'd0 : 6'd33);
            @(negedge clk);
            chk("err_pulse", {31'h0, load_error}, 32'h1);
            chk("err_stall", {31'h0, cpu_stall}, 32'h0);
            @(negedge clk);
            chk("err_one_cycle", {31'h0, load_error}, 32'h0);
        end
        chk("err_no_write", 32'(n_writes), 32'd2);

        // One-word load with a gap after every byte.
        @(posedge clk);
        words[0] = 32'hCAFE_F00D;
        #1 start_load(6'd1);
        send_words(1, 1);
        wait_done();
        chk("gap_mem0", mem[0], 32'hCAFE_F00D);
        chk("writes_after_gap", 32'(n_writes), 32'd3);

        // Reset after six bytes of a two-word load.
        @(posedge clk);
        words[0] = 32'h0BAD_C0DE;
        #1 start_load(6'd2);
        exp_q.push_back({32'h0, words[0]});
        for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8]);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        pc_address = 32'hC;
        #1;
        chk("mid_rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("mid_rst_ready", {31'h0, byte_ready}, 32'h0);
        chk("mid_rst_we", {31'h0, mem_write_en}, 32'h0);
        chk("mid_rst_addr", mem_address, 32'hC);
        chk("mid_rst_mem0", mem[0], 32'h0BAD_C0DE);
        chk("mid_rst_mem1", mem[1], 32'hDEAD_BEEF);
        chk("mid_rst_writes", 32'(n_writes), 32'd4);
        @(posedge clk);
        #1 reset = 1'b1;

        // A second request mid-load must not change the length.
        @(posedge clk);
        words[0] = 32'h5566_7788;
        #1 start_load(6'd1);
        exp_q.push_back({32'h0, words[0]});
        send_byte(8'h88);
        send_byte(8'h77);
        start_load(6'd5);
        send_byte(8'h66);
        send_byte(8'h55);
        wait_done();
        repeat (12) @(negedge clk);
        chk("relreq_writes", 32'(n_writes), 32'd5);
        chk("relreq_mem0", mem[0], 32'h5566_7788);
        chk("relreq_stall", {31'h0, cpu_stall}, 32'h0);
        w0 = exp_q.size();
        chk("queue_empty", 32'(w0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
